// File: rtl/aoc4_mem_pkg.sv
// rtl/aoc4_mem_pkg.sv - shared types and widths for the AOC4 bank client
// Purpose: command record, client FSM state encoding and width constants
//          shared by bank_client and cmd_fifo.
`ifndef BANK_ADDR_WIDTH
`define BANK_ADDR_WIDTH 8
`endif
`ifndef COL_ADDR_WIDTH
`define COL_ADDR_WIDTH 8
`endif
`ifndef TX_DATA_WIDTH
`define TX_DATA_WIDTH 16
`endif

package aoc4_mem_pkg;

  localparam int BANK_AW = `BANK_ADDR_WIDTH;
  localparam int COL_AW  = `COL_ADDR_WIDTH;
  localparam int TX_DW   = `TX_DATA_WIDTH;

  typedef struct packed {
    logic              is_write;
    logic [BANK_AW-1:0] row;
    logic [COL_AW-1:0]  col;
    logic [TX_DW-1:0]   data;
  } cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SETTLE,
    ST_WAIT,
    ST_RESP
  } client_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - in-order synchronous command FIFO
// Purpose: buffers cmd_t records between upstream and the client FSM.
// Ports:
//   clock, reset   posedge clock, synchronous active-high reset
//   push_i         write push_cmd_i at the tail (ignored when full)
//   push_cmd_i     command to store
//   pop_i          drop the head entry (ignored when empty)
//   head_o         current head entry (valid when !empty_o)
//   full_o         no free entries
//   empty_o        no stored entries
module cmd_fifo
  import aoc4_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push_i,
  input  cmd_t push_cmd_i,
  input  logic pop_i,
  output cmd_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);

  cmd_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (PW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers are PW bits wide, so increments wrap modulo DEPTH (power of two).
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_cmd_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW + 1)'(1);
        2'b01:   count_q <= count_q - (PW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bank_client.sv
// rtl/bank_client.sv - requester front end for BankController
// Purpose: queues upstream read/write commands, issues them one at a time to
//          the controller and returns read data as a one-cycle response.
// Ports:
//   clock, reset                  posedge clock, synchronous active-high reset
//   req_valid/req_ready           upstream command handshake
//   req_is_write/row/col/data     upstream command fields
//   rsp_valid/rsp_data            one-cycle read response
//   rsp_timeout                   qualifies rsp_valid: read was abandoned
//   timeout_err                   sticky: any timeout since reset
//   write_en/read_en              one-cycle command pulses to the controller
//   owner_row_addr/col_addr       address to the controller
//   partial_vec_in                write data to the controller
//   partial_vec_out/ack/busy      read data, read-valid and busy from controller
module bank_client
  import aoc4_mem_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = BANK_AW,
  parameter int COL_ADDR_WIDTH  = COL_AW,
  parameter int TX_DATA_WIDTH   = TX_DW,
  parameter int FIFO_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_write,
  input  logic [BANK_ADDR_WIDTH-1:0] req_row,
  input  logic [COL_ADDR_WIDTH-1:0]  req_col,
  input  logic [TX_DATA_WIDTH-1:0]   req_data,
  output logic                       rsp_valid,
  output logic [TX_DATA_WIDTH-1:0]   rsp_data,
  output logic                       rsp_timeout,
  output logic                       timeout_err,
  output logic                       write_en,
  output logic                       read_en,
  output logic [BANK_ADDR_WIDTH-1:0] owner_row_addr,
  output logic [COL_ADDR_WIDTH-1:0]  col_addr,
  output logic [TX_DATA_WIDTH-1:0]   partial_vec_in,
  input  logic [TX_DATA_WIDTH-1:0]   partial_vec_out,
  input  logic                       ack,
  input  logic                       busy
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle count before the command is abandoned.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  client_state_t              state_q;
  logic                       is_write_q;
  logic [CNT_W-1:0]           wait_cnt_q;
  logic                       write_en_q;
  logic                       read_en_q;
  logic [BANK_ADDR_WIDTH-1:0] row_q;
  logic [COL_ADDR_WIDTH-1:0]  col_q;
  logic [TX_DATA_WIDTH-1:0]   vec_in_q;
  logic                       rsp_valid_q;
  logic [TX_DATA_WIDTH-1:0]   rsp_data_q;
  logic                       rsp_timeout_q;
  logic                       timeout_err_q;

  cmd_t push_cmd;
  cmd_t head_cmd;
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  always_comb begin
    push_cmd          = '0;
    push_cmd.is_write = req_is_write;
    push_cmd.row      = req_row;
    push_cmd.col      = req_col;
    push_cmd.data     = req_data;
  end

  // Ready ignores a same-cycle pop so it depends only on registered state.
  assign req_ready = !fifo_full;
  assign push      = req_valid && !fifo_full;
  assign pop       = (state_q == ST_IDLE) && !fifo_empty && !busy;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .push_cmd_i (push_cmd),
    .pop_i      (pop),
    .head_o     (head_cmd),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      is_write_q    <= 1'b0;
      wait_cnt_q    <= '0;
      write_en_q    <= 1'b0;
      read_en_q     <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      vec_in_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            is_write_q <= head_cmd.is_write;
            write_en_q <= head_cmd.is_write;
            read_en_q  <= !head_cmd.is_write;
            row_q      <= head_cmd.row;
            col_q      <= head_cmd.col;
            vec_in_q   <= head_cmd.is_write ? head_cmd.data : '0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          write_en_q <= 1'b0;
          read_en_q  <= 1'b0;
          state_q    <= ST_SETTLE;
        end
        // The controller may raise busy a cycle late; skip this cycle.
        ST_SETTLE: begin
          wait_cnt_q <= '0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (is_write_q) begin
            if (!busy) begin
              state_q <= ST_IDLE;
            end else if (wait_cnt_q == CNT_LAST) begin
              timeout_err_q <= 1'b1;
              state_q       <= ST_IDLE;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
          end else begin
            // ack takes priority over busy and over an expiring timeout.
            if (ack) begin
              rsp_data_q    <= partial_vec_out;
              rsp_timeout_q <= 1'b0;
              rsp_valid_q   <= 1'b1;
              state_q       <= ST_RESP;
            end else if (wait_cnt_q == CNT_LAST) begin
              timeout_err_q <= 1'b1;
              rsp_data_q    <= '0;
              rsp_timeout_q <= 1'b1;
              rsp_valid_q   <= 1'b1;
              state_q       <= ST_RESP;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_RESP: begin
          rsp_valid_q   <= 1'b0;
          rsp_timeout_q <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign write_en       = write_en_q;
  assign read_en        = read_en_q;
  assign owner_row_addr = row_q;
  assign col_addr       = col_q;
  assign partial_vec_in = vec_in_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign timeout_err    = timeout_err_q;

endmodule
